// File: rtl/mpf_uart_hex_loader_if.sv
// mpf_uart_hex_loader_if: byte stream from the UART receiver plus the 32-bit
// word write port of the hex loader.
//   byte_data/byte_ready            : received byte and its one-cycle strobe
//   write_valid/address/data/ready  : word write request handshake
// master = the loader, slave = the side that feeds bytes and accepts writes.
interface mpf_uart_hex_loader_if;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        write_valid;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        write_ready;

    modport master (
        input  byte_data,
        input  byte_ready,
        input  write_ready,
        output write_valid,
        output write_address,
        output write_data
    );

    modport slave (
        output byte_data,
        output byte_ready,
        output write_ready,
        input  write_valid,
        input  write_address,
        input  write_data
    );
endinterface

// File: rtl/mpf_uart_hex_loader.sv
// mpf_uart_hex_loader: parses a readmemh-style ASCII stream ("@addr" tokens,
// hex data tokens, whitespace, "//" comments) arriving from a UART byte
// receiver and turns each data token into a 32-bit word write request.
// A load session is active from the first byte until timeout_cycles idle
// clocks have elapsed without a byte.
//   clock, reset   : system clock, synchronous active-high reset
//   bus            : byte input stream and word write handshake
//   in_progress    : load session active
//   word_count     : words committed in the current session
//   format_error   : sticky, a syntax error was seen
//   overrun_error  : sticky, a word was dropped behind an unaccepted request
module mpf_uart_hex_loader #(
    parameter int unsigned timeout_cycles = 2500000,
    parameter int unsigned timeout_width  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    mpf_uart_hex_loader_if.master bus,
    output logic                  in_progress,
    output logic [31:0]           word_count,
    output logic                  format_error,
    output logic                  overrun_error
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MAX_DIG = 8;

    localparam logic [2:0] ST_SEP     = 3'd0;
    localparam logic [2:0] ST_DATA    = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_SLASH   = 3'd3;
    localparam logic [2:0] ST_COMMENT = 3'd4;
    localparam logic [2:0] ST_SKIP    = 3'd5;

    localparam logic [timeout_width-1:0] IDLE_RELOAD = timeout_width'(timeout_cycles);
    localparam logic [timeout_width-1:0] IDLE_ONE    = timeout_width'(1);

    // Registered state
    logic [2:0]               r_state;
    logic [DATA_W-1:0]        r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [WADDR_W-1:0]       r_word_addr;
    logic [timeout_width-1:0] r_idle;
    logic                     r_in_progress;
    logic [31:0]              r_word_count;
    logic                     r_format_error;
    logic                     r_overrun_error;
    logic                     r_write_valid;
    logic [31:0]              r_write_address;
    logic [DATA_W-1:0]        r_write_data;

    // Next-state values
    logic [2:0]               w_state_nxt;
    logic [DATA_W-1:0]        w_acc_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [WADDR_W-1:0]       w_word_addr_nxt;
    logic [timeout_width-1:0] w_idle_nxt;
    logic                     w_in_progress_nxt;
    logic [31:0]              w_word_count_nxt;
    logic                     w_format_error_nxt;
    logic                     w_overrun_error_nxt;
    logic                     w_write_valid_nxt;
    logic [31:0]              w_write_address_nxt;
    logic [DATA_W-1:0]        w_write_data_nxt;

    // Character classification of the incoming byte
    logic              w_is_hex;
    logic              w_is_ws;
    logic              w_is_at;
    logic              w_is_slash;
    logic              w_is_lf;
    logic [3:0]        w_digit;
    logic [DATA_W-1:0] w_acc_shift;
    logic              w_acc_room;
    logic              w_timeout;
    logic              w_commit;
    logic              w_error;
    logic [31:0]       w_count_base;

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [3:0] v;
        v = 4'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            v = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            v = 4'(c - 8'h57);
        end
        return v;
    endfunction

    assign w_is_hex    = (bus.byte_data >= 8'h30 && bus.byte_data <= 8'h39) ||
                         (bus.byte_data >= 8'h41 && bus.byte_data <= 8'h46) ||
                         (bus.byte_data >= 8'h61 && bus.byte_data <= 8'h66);
    assign w_is_ws     = (bus.byte_data == 8'h20) || (bus.byte_data == 8'h09) ||
                         (bus.byte_data == 8'h0D) || (bus.byte_data == 8'h0A);
    assign w_is_at     = (bus.byte_data == 8'h40);
    assign w_is_slash  = (bus.byte_data == 8'h2F);
    assign w_is_lf     = (bus.byte_data == 8'h0A);
    assign w_digit     = hex_val(bus.byte_data);
    assign w_acc_shift = {r_acc[DATA_W-5:0], w_digit};
    assign w_acc_room  = (r_cnt < CNT_W'(MAX_DIG));

    // Session ends on the idle edge where the counter would reach zero
    assign w_timeout = r_in_progress && !bus.byte_ready && (r_idle <= IDLE_ONE);

    // First byte of a new session starts the word count afresh
    assign w_count_base = (bus.byte_ready && !r_in_progress) ? 32'd0 : r_word_count;

    // Parser, commit, handshake and session next-state logic
    always_comb begin
        w_state_nxt         = r_state;
        w_acc_nxt           = r_acc;
        w_cnt_nxt           = r_cnt;
        w_word_addr_nxt     = r_word_addr;
        w_idle_nxt          = r_idle;
        w_in_progress_nxt   = r_in_progress;
        w_word_count_nxt    = w_count_base;
        w_format_error_nxt  = r_format_error;
        w_overrun_error_nxt = r_overrun_error;
        w_write_valid_nxt   = r_write_valid;
        w_write_address_nxt = r_write_address;
        w_write_data_nxt    = r_write_data;
        w_commit            = 1'b0;
        w_error             = 1'b0;

        if (bus.byte_ready) begin
            case (r_state)
                ST_SEP: begin
                    if (w_is_ws) begin
                        w_state_nxt = ST_SEP;
                    end else if (w_is_hex) begin
                        w_state_nxt = ST_DATA;
                        w_acc_nxt   = DATA_W'(w_digit);
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (w_is_at) begin
                        w_state_nxt = ST_ADDR;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (w_is_slash) begin
                        w_state_nxt = ST_SLASH;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_is_hex) begin
                        if (w_acc_room) begin
                            w_acc_nxt = w_acc_shift;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end else begin
                            w_error = 1'b1;
                        end
                    end else if (w_is_ws) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_SEP;
                    end else if (w_is_slash) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_SLASH;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (w_is_hex) begin
                        if (w_acc_room) begin
                            w_acc_nxt = w_acc_shift;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end else begin
                            w_error = 1'b1;
                        end
                    end else if (w_is_ws && (r_cnt != '0)) begin
                        w_word_addr_nxt = r_acc[WADDR_W-1:0];
                        w_state_nxt     = ST_SEP;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                ST_SLASH: begin
                    if (w_is_slash) begin
                        w_state_nxt = ST_COMMENT;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                ST_COMMENT: begin
                    if (w_is_lf) begin
                        w_state_nxt = ST_SEP;
                    end
                end
                ST_SKIP: begin
                    if (w_is_ws) begin
                        w_state_nxt = ST_SEP;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEP;
                end
            endcase
        end else if (w_timeout) begin
            // Unterminated data token is flushed; partial address/slash is dropped
            if ((r_state == ST_DATA) && (r_cnt != '0)) begin
                w_commit = 1'b1;
            end
            w_state_nxt = ST_SEP;
        end

        if (w_error) begin
            w_format_error_nxt = 1'b1;
            w_state_nxt        = ST_SKIP;
        end

        // Accepted request retires unless replaced by a commit below
        if (r_write_valid && bus.write_ready) begin
            w_write_valid_nxt = 1'b0;
        end

        if (w_commit) begin
            if (!r_write_valid || bus.write_ready) begin
                w_write_valid_nxt   = 1'b1;
                w_write_address_nxt = {r_word_addr, 2'b00};
                w_write_data_nxt    = r_acc;
                w_word_count_nxt    = w_count_base + 32'd1;
            end else begin
                w_overrun_error_nxt = 1'b1;
            end
            w_word_addr_nxt = r_word_addr + WADDR_W'(1);
        end

        // Idle counter and session flag
        if (bus.byte_ready) begin
            w_idle_nxt        = IDLE_RELOAD;
            w_in_progress_nxt = 1'b1;
        end else if (r_in_progress) begin
            if (w_timeout) begin
                w_idle_nxt        = '0;
                w_in_progress_nxt = 1'b0;
            end else begin
                w_idle_nxt = r_idle - IDLE_ONE;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_SEP;
            r_acc           <= '0;
            r_cnt           <= '0;
            r_word_addr     <= '0;
            r_idle          <= '0;
            r_in_progress   <= 1'b0;
            r_word_count    <= '0;
            r_format_error  <= 1'b0;
            r_overrun_error <= 1'b0;
            r_write_valid   <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_acc           <= w_acc_nxt;
            r_cnt           <= w_cnt_nxt;
            r_word_addr     <= w_word_addr_nxt;
            r_idle          <= w_idle_nxt;
            r_in_progress   <= w_in_progress_nxt;
            r_word_count    <= w_word_count_nxt;
            r_format_error  <= w_format_error_nxt;
            r_overrun_error <= w_overrun_error_nxt;
            r_write_valid   <= w_write_valid_nxt;
            r_write_address <= w_write_address_nxt;
            r_write_data    <= w_write_data_nxt;
        end
    end

    assign bus.write_valid   = r_write_valid;
    assign bus.write_address = r_write_address;
    assign bus.write_data    = r_write_data;
    assign in_progress       = r_in_progress;
    assign word_count        = r_word_count;
    assign format_error      = r_format_error;
    assign overrun_error     = r_overrun_error;

endmodule

// File: tb/tb_mpf_uart_hex_loader.sv
// Testbench for mpf_uart_hex_loader: table of ASCII streams with expected
// writes/flags, plus hand-written sequences for backpressure, idle timeout
// and reset corner cases.
module tb_mpf_uart_hex_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_progress;
    logic [31:0] word_count;
    logic        format_error;
    logic        overrun_error;

    mpf_uart_hex_loader_if bus ();

    mpf_uart_hex_loader #(
        .timeout_cycles (16),
        .timeout_width  (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus.master),
        .in_progress   (in_progress),
        .word_count    (word_count),
        .format_error  (format_error),
        .overrun_error (overrun_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        string       text;
        int          nw;
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        logic        fe;
        logic [31:0] wc;
    } vec_t;

    wr_t  wq[$];
    int   checks   = 0;
    int   failures = 0;

    // Record every accepted write just before the accepting edge
    always @(negedge clock) begin
        if (!reset && bus.write_valid && bus.write_ready) begin
            wq.push_back({bus.write_address, bus.write_data});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wq.delete();
    endtask

    // Present one byte for exactly one clock; returns just after its sampling edge
    task automatic send_byte(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(1);
        end
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [31:0] a, input logic [31:0] d);
        if (idx < wq.size()) begin
            check({name, "_addr"}, wq[idx].a, a);
            check({name, "_data"}, wq[idx].d, d);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: write %0d missing, got %0d writes", name, idx, wq.size());
        end
    endtask

    function automatic vec_t mk(input string t, input int nw,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic [31:0] a2, input logic [31:0] d2,
                                input logic fe, input logic [31:0] wc);
        vec_t v;
        v.text = t;
        v.nw   = nw;
        v.wa[0] = a0; v.wd[0] = d0;
        v.wa[1] = a1; v.wd[1] = d1;
        v.wa[2] = a2; v.wd[2] = d2;
        v.fe = fe;
        v.wc = wc;
        return v;
    endfunction

    vec_t vecs [12];

    initial begin
        bool_dummy_init();
    end

    task automatic bool_dummy_init();
        reset = 1'b1;
        bus.byte_ready  = 1'b0;
        bus.byte_data   = 8'h00;
        bus.write_ready = 1'b0;
    endtask

    initial begin
        int  early_drop;
        vecs[0]  = mk("@10 DEADBEEF 1\n", 2, 32'h40, 32'hDEADBEEF, 32'h44, 32'h1, 0, 0, 1'b0, 2);
        vecs[1]  = mk("// hi @5\nCAFE ", 1, 32'h0, 32'h0000CAFE, 0, 0, 0, 0, 1'b0, 1);
        vecs[2]  = mk("123456789 AB ",   1, 32'h0, 32'h000000AB, 0, 0, 0, 0, 1'b1, 1);
        vecs[3]  = mk("@3FFFFFFF 7 8 ",  2, 32'hFFFFFFFC, 32'h7, 32'h0, 32'h8, 0, 0, 1'b0, 2);
        vecs[4]  = mk("x 5 ",            1, 32'h0, 32'h5, 0, 0, 0, 0, 1'b1, 1);
        vecs[5]  = mk("@ 5 6 ",          1, 32'h0, 32'h6, 0, 0, 0, 0, 1'b1, 1);
        vecs[6]  = mk("/x 9 ",           1, 32'h0, 32'h9, 0, 0, 0, 0, 1'b1, 1);
        vecs[7]  = mk("1//c\n2 ",        2, 32'h0, 32'h1, 32'h4, 32'h2, 0, 0, 1'b0, 2);
        vecs[8]  = mk("aBcDeF01 ",       1, 32'h0, 32'hABCDEF01, 0, 0, 0, 0, 1'b0, 1);
        vecs[9]  = mk("12\t34\01556 ",   3, 32'h0, 32'h12, 32'h4, 32'h34, 32'h8, 32'h56, 1'b0, 3);
        vecs[10] = mk("AA",              1, 32'h0, 32'hAA, 0, 0, 0, 0, 1'b0, 1);
        vecs[11] = mk("@5",              0, 0, 0, 0, 0, 0, 0, 1'b0, 0);

        // Reset state
        do_reset();
        check("rst_valid", 32'(bus.write_valid), 0);
        check("rst_addr", bus.write_address, 0);
        check("rst_data", bus.write_data, 0);
        check("rst_inprog", 32'(in_progress), 0);
        check("rst_wc", word_count, 0);
        check("rst_fe", 32'(format_error), 0);
        check("rst_ov", 32'(overrun_error), 0);

        // Table-driven streams, write_ready held high
        for (int v = 0; v < 12; v++) begin
            do_reset();
            bus.write_ready = 1'b1;
            send_str(vecs[v].text);
            idle(25);
            check($sformatf("v%0d_nw", v), 32'(wq.size()), 32'(vecs[v].nw));
            for (int k = 0; k < vecs[v].nw; k++) begin
                check_write($sformatf("v%0d_w%0d", v, k), k, vecs[v].wa[k], vecs[v].wd[k]);
            end
            check($sformatf("v%0d_fe", v), 32'(format_error), 32'(vecs[v].fe));
            check($sformatf("v%0d_ov", v), 32'(overrun_error), 0);
            check($sformatf("v%0d_wc", v), word_count, vecs[v].wc);
            check($sformatf("v%0d_inprog", v), 32'(in_progress), 0);
        end

        // Backpressure: second word dropped, first request held stable
        do_reset();
        bus.write_ready = 1'b0;
        send_str("1 2 ");
        check("ovr_valid", 32'(bus.write_valid), 1);
        check("ovr_addr", bus.write_address, 32'h0);
        check("ovr_data", bus.write_data, 32'h1);
        check("ovr_flag", 32'(overrun_error), 1);
        check("ovr_wc", word_count, 1);
        idle(20);
        check("ovr_survive_valid", 32'(bus.write_valid), 1);
        check("ovr_survive_data", bus.write_data, 32'h1);
        check("ovr_session_end", 32'(in_progress), 0);
        bus.write_ready = 1'b1;
        idle(3);
        check("ovr_accept_n", 32'(wq.size()), 1);
        check_write("ovr_accept", 0, 32'h0, 32'h1);
        check("ovr_valid_clr", 32'(bus.write_valid), 0);
        send_str("3 ");
        idle(2);
        check_write("ovr_next", 1, 32'h8, 32'h3);
        check("ovr_sticky", 32'(overrun_error), 1);

        // Idle timeout flushes an unterminated token, then a new session restarts the count
        do_reset();
        bus.write_ready = 1'b1;
        send_byte(8'h41);
        idle(1);
        send_byte(8'h41);
        early_drop = 0;
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            if (k < 16 && !in_progress) early_drop = 1;
            if (k < 16 && bus.write_valid) early_drop = 1;
        end
        check("to_hold", 32'(early_drop), 0);
        check("to_drop", 32'(in_progress), 0);
        check("to_valid", 32'(bus.write_valid), 1);
        check("to_data", bus.write_data, 32'hAA);
        check("to_wc", word_count, 1);
        send_byte(8'h35);
        check("to_restart_wc", word_count, 0);
        check("to_restart_inprog", 32'(in_progress), 1);
        idle(1);
        send_str(" ");
        idle(2);
        check("to_nw", 32'(wq.size()), 2);
        check_write("to_w0", 0, 32'h0, 32'hAA);
        check_write("to_w1", 1, 32'h4, 32'h5);
        check("to_wc2", word_count, 1);

        // Reset mid-token discards it
        do_reset();
        bus.write_ready = 1'b1;
        send_str("12");
        do_reset();
        send_str(" ");
        idle(3);
        check("rtok_nw", 32'(wq.size()), 0);
        check("rtok_valid", 32'(bus.write_valid), 0);

        // Reset mid-handshake drops the pending request
        bus.write_ready = 1'b0;
        send_str("1 ");
        check("rhs_valid_before", 32'(bus.write_valid), 1);
        do_reset();
        check("rhs_valid_after", 32'(bus.write_valid), 0);
        bus.write_ready = 1'b1;
        idle(3);
        check("rhs_nw", 32'(wq.size()), 0);
        check("rhs_wc", word_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
